// File: rtl/jk_pkg.sv
// JK flip-flop excitation codes and helpers shared by the modulo counter and its cells.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RST0   = 2'b01,
        JK_SET1   = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_op_e;

    // Count path only ever toggles or holds; set/reset codes are reserved for load.
    function automatic jk_op_e jk_excite(input logic cur, input logic nxt);
        return (cur ^ nxt) ? JK_TOGGLE : JK_HOLD;
    endfunction

    function automatic jk_op_e jk_load(input logic d);
        return d ? JK_SET1 : JK_RST0;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset; J=K=0 is a true hold.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case (jk_op_e'({j, k}))
                JK_HOLD:   q <= q;
                JK_RST0:   q <= 1'b0;
                JK_SET1:   q <= 1'b1;
                JK_TOGGLE: q <= ~q;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter whose state is held in a bank of jk_cell instances.
// Optional JK_MOD_COUNTER_GRAY_EN adds a combinational Gray-coded view q_gray.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
`ifdef JK_MOD_COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] q_gray
`endif
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_VAL = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    jk_op_e           op;

    always_comb begin
        q_next = q;
        if (load) begin
            q_next = ({1'b0, load_val} >= MOD_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            if (up) begin
                // >= also sends an out-of-range state back to 0
                q_next = (q >= MAX_VAL) ? '0 : q + 1'b1;
            end else begin
                q_next = (q == '0) ? MAX_VAL : q - 1'b1;
            end
        end
    end

    always_comb begin
        j  = '0;
        k  = '0;
        op = JK_HOLD;
        for (int i = 0; i < WIDTH; i++) begin
            op         = load ? jk_load(q_next[i]) : jk_excite(q[i], q_next[i]);
            {j[i], k[i]} = op;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cells
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j[g]),
            .k   (k[g]),
            .q   (q[g])
        );
    end

    assign tc = ~rst & en & ~load & (up ? (q == MAX_VAL) : (q == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap <= 1'b0;
        end else begin
            wrap <= tc;
        end
    end

`ifdef JK_MOD_COUNTER_GRAY_EN
    assign q_gray = q ^ (q >> 1);
`endif

endmodule

// File: tb/tb_jk_mod_counter.sv
// Directed, table-driven self-checking bench for jk_mod_counter (WIDTH=4, MODULUS=10).
module tb_jk_mod_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load;
    logic [3:0] load_val;
    logic [3:0] q;
    logic       tc, wrap;
`ifdef JK_MOD_COUNTER_GRAY_EN
    logic [3:0] q_gray;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    jk_mod_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tc       (tc),
        .wrap     (wrap)
`ifdef JK_MOD_COUNTER_GRAY_EN
        ,
        .q_gray   (q_gray)
`endif
    );

    // Inputs applied before an edge; tc expected before that edge, q/wrap after it.
    typedef struct {
        logic       rst;
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] lv;
        logic       tc;
        logic [3:0] q;
        logic       wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, e, u, l, input logic [3:0] lv,
                       input logic etc, input logic [3:0] eq, input logic ew);
        vec_t v;
        v.rst = r; v.en = e; v.up = u; v.load = l; v.lv = lv;
        v.tc = etc; v.q = eq; v.wrap = ew;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, e, u, l, input logic [3:0] lv);
        rst = r; en = e; up = u; load = l; load_val = lv;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int wraps;
`ifdef JK_MOD_COUNTER_GRAY_EN
    logic [3:0] gray_exp [10];
`endif

    initial begin
        drive(1, 1, 1, 1, 4'd5);

        // reset with every other control active
        add(1, 1, 1, 1, 4'd5, 0, 4'd0, 0);
        add(1, 1, 1, 1, 4'd5, 0, 4'd0, 0);
        // up count through the wrap
        for (int i = 0; i < 9; i++) add(0, 1, 1, 0, 4'd0, 0, 4'(i + 1), 0);
        add(0, 1, 1, 0, 4'd0, 1, 4'd0, 1);
        add(0, 0, 1, 0, 4'd0, 0, 4'd0, 0);
        // down count through the wrap
        add(0, 1, 0, 1, 4'd0, 0, 4'd0, 0);
        add(0, 1, 0, 0, 4'd0, 1, 4'd9, 1);
        add(0, 1, 0, 0, 4'd0, 0, 4'd8, 0);
        add(0, 1, 0, 0, 4'd0, 0, 4'd7, 0);
        // load priority and clamp
        add(0, 1, 1, 1, 4'd4, 0, 4'd4, 0);
        add(0, 1, 1, 1, 4'd13, 0, 4'd9, 0);
        // hold, then direction flip at the terminal
        for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 4'd0, 0, 4'd9, 0);
        add(0, 1, 0, 0, 4'd0, 0, 4'd8, 0);
        // load beats en at the terminal: no tc, no wrap
        add(0, 0, 1, 1, 4'd9, 0, 4'd9, 0);
        add(0, 1, 1, 1, 4'd2, 0, 4'd2, 0);
        // reset at the terminal discards the pending wrap
        add(0, 0, 1, 1, 4'd9, 0, 4'd9, 0);
        add(1, 1, 1, 0, 4'd0, 0, 4'd0, 0);
        add(0, 0, 1, 0, 4'd0, 0, 4'd0, 0);

        #2;
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].lv);
            #1;
            check("tc", i, 32'(tc), 32'(vecs[i].tc));
            tick();
            check("q", i, 32'(q), 32'(vecs[i].q));
            check("wrap", i, 32'(wrap), 32'(vecs[i].wrap));
        end

        // free-running up count: 25 edges from 0 give two single-cycle wrap pulses
        wraps = 0;
        drive(0, 1, 1, 0, 4'd0);
        for (int i = 0; i < 25; i++) begin
            tick();
            if (wrap) wraps++;
        end
        check("wrap_count", 25, 32'(wraps), 32'd2);
        check("q_after_run", 25, 32'(q), 32'd5);

        // out-of-range load is clamped, so a following up count wraps to 0
        drive(0, 0, 1, 1, 4'd15);
        tick();
        check("clamp15", 0, 32'(q), 32'd9);

`ifdef JK_MOD_COUNTER_GRAY_EN
        gray_exp = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12, 4'd13};
        drive(1, 1, 1, 1, 4'd7);
        tick();
        check("gray_rst", 0, 32'(q_gray), 32'd0);
        drive(0, 1, 1, 0, 4'd0);
        for (int i = 0; i < 10; i++) begin
            #1;
            check("gray", i, 32'(q_gray), 32'(gray_exp[i]));
            tick();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jk_mod_counter.md
Name: jk_mod_counter

Overview:
- Synchronous modulo-N up/down counter whose state bits are held exclusively in a bank of JK flip-flop cells.
- The block consists of the excitation stage that directly feeds those cells: it computes each cell's J/K inputs from current state and controls.
- Used as the Lab5 follow-on: a JK-based counter driving display/sequence logic downstream.

Parameters:
- WIDTH, 4, number of state bits / JK cells.
- MODULUS, 10, count range 0..MODULUS-1. Requires 2 <= MODULUS <= 2**WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- load_val  input  WIDTH  value to load.
- q  output  WIDTH  current count, taken directly from the JK cell outputs.
- tc  output  1  terminal count, combinational.
- wrap  output  1  registered one-cycle pulse after a wrap.

Behaviour:
- Clocking and reset:
  - One clock (clk). rst is synchronous and active-high.
  - On reset: q=0, wrap=0. Reset takes priority over every other input.
- Priority per rising edge: rst > load > en > hold.
- Load:
  - q_next = load_val.
  - If load_val >= MODULUS, q_next = MODULUS-1 (clamp).
  - Load never asserts wrap.
- Count (en=1, load=0):
  - up=1: q_next = (q==MODULUS-1) ? 0 : q+1.
  - up=0: q_next = (q==0) ? MODULUS-1 : q-1.
- Hold (en=0, load=0): q unchanged.
- Excitation rules (the contract with the cells):
  - Count and hold: per bit i, j[i]=k[i]=q[i]^q_next[i]. That is toggle-or-hold; the set/reset codes are never used when counting.
  - Load: j[i]=q_next[i], k[i]=~q_next[i].
  - The J=K=0 hold code must give a true hold. The cell has no implicit reset from undriven state.
- Latency: q reflects the new value 1 cycle after the controlling edge. No combinational path from inputs to q.
- tc:
  - tc = en & ~load & (up ? q==MODULUS-1 : q==0).
  - tc is 0 while rst=1.
- wrap:
  - Registered. wrap=1 for exactly the cycle after an edge where tc=1 and rst=0; otherwise wrap=0.
- Boundary cases:
  - Direction change at the terminal: a wrap only occurs if tc is evaluated with the new direction. Example: q=9 with up=0 decrements to 8, no wrap.
  - Out-of-range state (q >= MODULUS) is unreachable by construction, but if present, counting up goes to 0 and tc=0.
  - MODULUS == 2**WIDTH: wrap is natural overflow. The same rules still apply.
  - Reset asserted mid-count or during load: q=0 and wrap=0 on that edge. Pending load or wrap is discarded.
  - load and en both high: load wins, tc=0, no wrap.

Optional Feature:
- Macro: JK_MOD_COUNTER_GRAY_EN.
- Defined:
  - Adds output port q_gray (WIDTH) = q ^ (q >> 1), combinational from q. Zero added latency.
  - q_gray = 0 during and after reset.
- Undefined: port q_gray is absent. All other behaviour is identical.

Decomposition:
- Package jk_pkg:
  - enum jk_op_e {JK_HOLD=2'b00, JK_RST0=2'b01, JK_SET1=2'b10, JK_TOGGLE=2'b11}, encoded {j,k}.
  - Function jk_excite(cur, nxt) returning jk_op_e for the count path.
  - Function jk_load(d) returning SET1/RST0.
- Sub-module jk_cell:
  - Single JK flip-flop with sync active-high rst (rst forces q=0).
  - Instantiated WIDTH times via generate.
  - All count state lives in jk_cell instances; only wrap is a plain flop.

Test Plan (WIDTH=4, MODULUS=10):
- Reset: rst=1 for 2 cycles with en=1, up=1, load=1, load_val=5 -> q=0, wrap=0, tc=0 throughout. First count edge after release gives q=1.
- Up wrap: en=1, up=1 from 0 for 10 cycles -> q=1..9 then 0. tc=1 only while q=9. wrap=1 the single cycle q=0 is shown.
- Down wrap: load 0, then en=1, up=0 -> q=9, 8, 7. tc=1 at q=0. wrap pulses once after 0->9.
- Load priority and clamp: load=1 with en=1, load_val=4 -> q=4, no wrap. load_val=13 -> q=9.
- Hold and direction flip: q=9, en=0 for 3 cycles -> q=9 stable, tc=0. Then en=1, up=0 -> q=8, wrap=0.
- Mid-operation reset: rst=1 on the cycle q=9, en=1, up=1 -> q=0, wrap=0 next cycle (no pulse). With JK_MOD_COUNTER_GRAY_EN, check q_gray = 0,1,3,2,6,7,5,4,12,13 across 0..9.
